snes_autojoy_seq: RTL and testbench
===================================

Name: snes_autojoy_seq

Overview:
Sequencer for the SNES serial joypad interface: on each auto-read trigger (vblank) it drives strobe and clock to the pad bridges and shifts 16 bits from each of two ports into the JOY1/JOY2 result registers. It also arbitrates the shared strb/clk lines between the auto-read engine and manual CPU access through $4016. It sits between the CPU I/O register block and the two pad bridges.

Parameters:
HALF_CYC, 64, cycles per half joy-clock period (≈6 µs at 10.8 MHz); legal range ≥2
NBITS, 16, bits clocked per auto-read

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
autojoy_en  in  1  auto-read enable (NMITIMEN bit 0); sampled only when start is accepted
start  in  1  one-cycle auto-read trigger
manual_strb  in  1  CPU-driven strobe ($4016 bit 0)
manual_clk  in  1  CPU-driven joy clock (idle high)
joy1_di  in  1  port 1 serial data, active-low
joy2_di  in  1  port 2 serial data, active-low
joy_strb  out  1  strobe to both pads (registered)
joy_clk  out  1  clock to both pads; falling edge shifts pad (registered)
busy  out  1  auto-read in progress (HVBJOY bit 0)
done  out  1  one-cycle pulse when results update
joy1_data  out  16  port 1 result; bit 15 = first bit shifted (B)
joy2_data  out  16  port 2 result

Behaviour:
- Reset: joy_strb=0, joy_clk=1, busy=0, done=0, joy1_data=joy2_data=0, shift regs=0, state IDLE. Reset asserted mid-read aborts immediately; results stay 0.
- States: IDLE, STROBE, SETTLE, CLK_LO, CLK_HI. Down-counter loaded with phase length on each state entry.
- IDLE: joy_strb<=manual_strb, joy_clk<=manual_clk (1-cycle latency). start && autojoy_en -> STROBE; start with autojoy_en=0 is ignored.
- STROBE: 2*HALF_CYC cycles, joy_strb=1, joy_clk=1 -> SETTLE.
- SETTLE: HALF_CYC cycles, strb=0, clk=1. On its last cycle, sample bit 0 -> CLK_LO.
- CLK_LO: HALF_CYC cycles, clk=0 -> CLK_HI.
- CLK_HI: HALF_CYC cycles, clk=1. On its last cycle: if bit counter < NBITS-1, sample next bit -> CLK_LO; else -> IDLE.
- Sample: shN <= {shN[14:0], ~joyN_di}. Exactly 16 samples and 16 falling edges per read.
- Completion: on the CLK_HI -> IDLE transition, joyN_data <= shN atomically, and done pulses on the following cycle. joyN_data is otherwise stable during a read.
- busy is high from the cycle after start is accepted through the last CLK_HI cycle. Total read length is 35*HALF_CYC cycles (2240 at default).
- While busy, start and the manual_* inputs are ignored; the sequencer owns the lines. If start and manual activity coincide in IDLE, the sequencer wins.
- A change of autojoy_en mid-read has no effect; the read completes.
- Bit counter is 4 bits and does not wrap within a read.

Optional Feature:
SNES_AUTOJOY_READ_COUNT_EN: when defined, adds an output read_count[7:0] that increments (wrapping 255->0) in the same cycle done pulses, and resets to 0. When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package snes_joy_pkg: state enum (IDLE, STROBE, SETTLE, CLK_LO, CLK_HI), NBITS constant, default HALF_CYC constant, button bit positions for the 16-bit result word (B=15, Y=14, SEL=13, ST=12, UP=11, DN=10, LT=9, RT=8, A=7, X=6, L=5, R=4).
- Sub-module joy_phase_timer (load value, terminal-count flag) is natural; the rest stays flat.

Test Plan:
- HALF_CYC=4, both pad models hold pattern 0x8F30 -> after start, 16 joy_clk falls, busy high for 140 cycles, done pulse, joy1_data=joy2_data=0x8F30.
- start with autojoy_en=0 -> no strobe, busy stays 0, data unchanged.
- Second start at cycle 10 of a read -> ignored; exactly one done pulse; pad-side falling-edge count=16.
- manual_strb/manual_clk toggled while idle -> joy_strb/joy_clk follow one cycle later; toggled while busy -> outputs unaffected.
- reset asserted at cycle 50 of a read -> outputs immediately strb=0, clk=1, busy=0, data=0; next start completes a normal read.
- With SNES_AUTOJOY_READ_COUNT_EN, 257 reads -> read_count=1.

Source files
------------

// File: rtl/snes_joy_pkg.sv
// snes_joy_pkg: shared constants for the SNES joypad auto-read sequencer
// (state codes, default timing, button bit positions in the result word).
package snes_joy_pkg;

  localparam int JOY_NBITS    = 16;
  localparam int JOY_HALF_CYC = 64;

  typedef logic [2:0] joy_state_t;

  localparam joy_state_t ST_IDLE   = 3'd0;
  localparam joy_state_t ST_STROBE = 3'd1;
  localparam joy_state_t ST_SETTLE = 3'd2;
  localparam joy_state_t ST_CLK_LO = 3'd3;
  localparam joy_state_t ST_CLK_HI = 3'd4;

  // Button positions; the first bit shifted out of the pad lands in bit 15.
  localparam int BTN_B   = 15;
  localparam int BTN_Y   = 14;
  localparam int BTN_SEL = 13;
  localparam int BTN_ST  = 12;
  localparam int BTN_UP  = 11;
  localparam int BTN_DN  = 10;
  localparam int BTN_LT  = 9;
  localparam int BTN_RT  = 8;
  localparam int BTN_A   = 7;
  localparam int BTN_X   = 6;
  localparam int BTN_L   = 5;
  localparam int BTN_R   = 4;

endpackage

// File: rtl/joy_phase_timer.sv
// joy_phase_timer: loadable down-counter; tc is high on the last cycle of a phase
// (a phase of N cycles is started by loading N-1).
module joy_phase_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/snes_autojoy_seq.sv
// snes_autojoy_seq: SNES joypad auto-read sequencer with manual $4016 strobe/clock passthrough.
// Optional: define SNES_AUTOJOY_READ_COUNT_EN to add the read_count output.
module snes_autojoy_seq
  import snes_joy_pkg::*;
#(
  parameter int HALF_CYC = JOY_HALF_CYC,
  parameter int NBITS    = JOY_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             autojoy_en,
  input  logic             start,
  input  logic             manual_strb,
  input  logic             manual_clk,
  input  logic             joy1_di,
  input  logic             joy2_di,
  output logic             joy_strb,
  output logic             joy_clk,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] joy1_data,
  output logic [NBITS-1:0] joy2_data
`ifdef SNES_AUTOJOY_READ_COUNT_EN
  ,
  output logic [7:0]       read_count
`endif
);

  localparam int CW = $clog2(2 * HALF_CYC);
  localparam logic [CW-1:0] LEN_STROBE = CW'(2 * HALF_CYC - 1);
  localparam logic [CW-1:0] LEN_HALF   = CW'(HALF_CYC - 1);
  localparam logic [3:0]    LAST_BIT   = 4'(NBITS - 1);

  joy_state_t      state, state_nxt;
  logic            load, tc, sample, finish;
  logic [CW-1:0]   load_val;
  logic [3:0]      bit_cnt;
  logic [NBITS-1:0] sh1, sh2;

  joy_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = LEN_HALF;
    sample    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && autojoy_en) begin
          state_nxt = ST_STROBE;
          load      = 1'b1;
          load_val  = LEN_STROBE;
        end
      end
      ST_STROBE: begin
        if (tc) begin
          state_nxt = ST_SETTLE;
          load      = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tc) begin
          state_nxt = ST_CLK_LO;
          load      = 1'b1;
          sample    = 1'b1;
        end
      end
      ST_CLK_LO: begin
        if (tc) begin
          state_nxt = ST_CLK_HI;
          load      = 1'b1;
        end
      end
      ST_CLK_HI: begin
        if (tc) begin
          if (bit_cnt < LAST_BIT) begin
            state_nxt = ST_CLK_LO;
            load      = 1'b1;
            sample    = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            finish    = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pad lines are registered from the next state so they change with the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      joy_strb  <= 1'b0;
      joy_clk   <= 1'b1;
      done      <= 1'b0;
      bit_cnt   <= '0;
      sh1       <= '0;
      sh2       <= '0;
      joy1_data <= '0;
      joy2_data <= '0;
    end else begin
      state <= state_nxt;
      done  <= finish;
      if (state == ST_IDLE && state_nxt == ST_STROBE) begin
        bit_cnt <= '0;
      end else if (state == ST_CLK_HI && sample) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (sample) begin
        sh1 <= {sh1[NBITS-2:0], ~joy1_di};
        sh2 <= {sh2[NBITS-2:0], ~joy2_di};
      end
      if (finish) begin
        joy1_data <= sh1;
        joy2_data <= sh2;
      end
      case (state_nxt)
        ST_IDLE: begin
          joy_strb <= manual_strb;
          joy_clk  <= manual_clk;
        end
        ST_STROBE: begin
          joy_strb <= 1'b1;
          joy_clk  <= 1'b1;
        end
        ST_CLK_LO: begin
          joy_strb <= 1'b0;
          joy_clk  <= 1'b0;
        end
        default: begin
          joy_strb <= 1'b0;
          joy_clk  <= 1'b1;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef SNES_AUTOJOY_READ_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_count <= '0;
    end else if (finish) begin
      read_count <= read_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snes_autojoy_seq.sv
// tb_snes_autojoy_seq: randomized scoreboard bench for snes_autojoy_seq with two pad models.
// Covers the SNES_AUTOJOY_READ_COUNT_EN build when that macro is defined.
module tb_snes_autojoy_seq;

  localparam int HC = 4;
  localparam int NB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        autojoy_en, start, manual_strb, manual_clk;
  logic        joy1_di, joy2_di;
  logic        joy_strb, joy_clk, busy, done;
  logic [15:0] joy1_data, joy2_data;
`ifdef SNES_AUTOJOY_READ_COUNT_EN
  logic [7:0]  read_count;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int n_reads = 0;
  logic [31:0] exp_q[$];

  snes_autojoy_seq #(.HALF_CYC(HC), .NBITS(NB)) dut (
    .clk         (clk),
    .reset       (reset),
    .autojoy_en  (autojoy_en),
    .start       (start),
    .manual_strb (manual_strb),
    .manual_clk  (manual_clk),
    .joy1_di     (joy1_di),
    .joy2_di     (joy2_di),
    .joy_strb    (joy_strb),
    .joy_clk     (joy_clk),
    .busy        (busy),
    .done        (done),
    .joy1_data   (joy1_data),
    .joy2_data   (joy2_data)
`ifdef SNES_AUTOJOY_READ_COUNT_EN
    ,
    .read_count  (read_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Pad model: latch buttons while strobe is high, shift on each falling joy_clk.
  logic [15:0] pad1_pat = '0, pad2_pat = '0;
  logic [15:0] pad1_sr = '0, pad2_sr = '0;
  logic        pad_clk_prev = 1'b1;

  always @(negedge clk) begin
    if (joy_strb) begin
      pad1_sr = pad1_pat;
      pad2_sr = pad2_pat;
    end else if (pad_clk_prev && !joy_clk) begin
      pad1_sr = {pad1_sr[14:0], 1'b0};
      pad2_sr = {pad2_sr[14:0], 1'b0};
    end
    pad_clk_prev = joy_clk;
  end

  assign joy1_di = ~pad1_sr[15];
  assign joy2_di = ~pad2_sr[15];

  // Monitor: line waveform expected from the cycle offset inside a read, result scoreboard.
  int          busy_t = 0, falls = 0, wave_err = 0, model_reads = 0;
  logic        busy_prev = 1'b0, mon_clk_prev = 1'b1;
  logic        exp_strb, exp_clk;
  logic [15:0] exp1 = '0, exp2 = '0;
  logic [31:0] e;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp1 = '0;
      exp2 = '0;
      busy_t = 0;
      falls = 0;
      wave_err = 0;
      model_reads = 0;
      busy_prev = 1'b0;
      mon_clk_prev = 1'b1;
    end else begin
      if (busy) begin
        exp_strb = (busy_t < 2 * HC);
        exp_clk  = !(busy_t >= 3 * HC && ((busy_t - 3 * HC) / HC) % 2 == 0);
        if (joy_strb !== exp_strb || joy_clk !== exp_clk) wave_err++;
        if (joy1_data !== exp1 || joy2_data !== exp2) wave_err++;
        if (mon_clk_prev && !joy_clk) falls++;
        busy_t++;
      end else if (busy_prev) begin
        checkOutput("busy_len", busy_t, 35 * HC);
        checkOutput("clk_falls", falls, NB);
        checkOutput("wave_errs", wave_err, 0);
        busy_t = 0;
        falls = 0;
        wave_err = 0;
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("spurious_done", 32'(done), 0);
        end else begin
          e = exp_q.pop_front();
          exp1 = e[31:16];
          exp2 = e[15:0];
          model_reads++;
          checkOutput("joy1_data", 32'(joy1_data), 32'(exp1));
          checkOutput("joy2_data", 32'(joy2_data), 32'(exp2));
`ifdef SNES_AUTOJOY_READ_COUNT_EN
          checkOutput("read_count", 32'(read_count), model_reads % 256);
`endif
        end
      end
      mon_clk_prev = joy_clk;
      busy_prev = busy;
    end
  end

  task automatic applyStimulus(input logic en, input logic [15:0] p1, input logic [15:0] p2);
    @(negedge clk);
    pad1_pat   = p1;
    pad2_pat   = p2;
    autojoy_en = en;
    start      = 1'b1;
    if (en) exp_q.push_back({p1, p2});
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic runRead(input logic [15:0] p1, input logic [15:0] p2,
                         input bit toggle_manual, input bit restart);
    int target;
    target = done_cnt + 1;
    applyStimulus(1'b1, p1, p2);
    n_reads++;
    for (int i = 0; i < 35 * HC + 20 && done_cnt < target; i++) begin
      @(negedge clk);
      start = restart && (i == 8);
      if (toggle_manual) begin
        manual_strb = 1'($urandom);
        manual_clk  = 1'($urandom);
      end
    end
    start       = 1'b0;
    manual_strb = 1'b0;
    manual_clk  = 1'b1;
    checkOutput("done_seen", 32'(done_cnt >= target), 1);
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic busy_seen, strb_seen, ms, mc, last_s, last_c;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    autojoy_en  = 1'b0;
    manual_strb = 1'b0;
    manual_clk  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_strb", 32'(joy_strb), 0);
    checkOutput("rst_clk", 32'(joy_clk), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_joy1", 32'(joy1_data), 0);
    checkOutput("rst_joy2", 32'(joy2_data), 0);
    #2 reset = 1'b0;

    runRead(16'h8F30, 16'h8F30, 1'b0, 1'b0);
    checkOutput("basic_joy1", 32'(joy1_data), 32'h8F30);

    applyStimulus(1'b0, 16'h1234, 16'h5678);
    busy_seen = 1'b0;
    strb_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (joy_strb) strb_seen = 1'b1;
    end
    checkOutput("disabled_busy", 32'(busy_seen), 0);
    checkOutput("disabled_strb", 32'(strb_seen), 0);
    checkOutput("disabled_data", 32'(joy1_data), 32'h8F30);

    for (int k = 0; k < 3; k++) begin
      runRead(16'($urandom), 16'($urandom), k == 1, k == 2);
    end
    runRead(16'h0000, 16'hFFFF, 1'b0, 1'b1);
    runRead(16'hFFFF, 16'h0001, 1'b1, 1'b0);

    last_s = 1'b0;
    last_c = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ms = k[0];
      mc = ~k[1];
      manual_strb = ms;
      manual_clk  = mc;
      #1;
      checkOutput("manual_strb_hold", 32'(joy_strb), 32'(last_s));
      checkOutput("manual_clk_hold", 32'(joy_clk), 32'(last_c));
      @(posedge clk);
      #1;
      checkOutput("manual_strb_follow", 32'(joy_strb), 32'(ms));
      checkOutput("manual_clk_follow", 32'(joy_clk), 32'(mc));
      last_s = ms;
      last_c = mc;
    end
    manual_strb = 1'b0;
    manual_clk  = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(1'b1, 16'hA5C3, 16'h3C5A);
    repeat (50) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_strb", 32'(joy_strb), 0);
    checkOutput("abort_clk", 32'(joy_clk), 1);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_joy1", 32'(joy1_data), 0);
    checkOutput("abort_joy2", 32'(joy2_data), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    runRead(16'h5A0F, 16'hC3A5, 1'b0, 1'b0);
    checkOutput("post_abort_joy2", 32'(joy2_data), 32'hC3A5);

`ifdef SNES_AUTOJOY_READ_COUNT_EN
    for (int k = 0; k < 256; k++) begin
      runRead(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    end
    checkOutput("read_count_257", 32'(read_count), 1);
`endif

    repeat (4) @(negedge clk);
    checkOutput("done_count", done_cnt, n_reads);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
